// File: rtl/ms53l_pkg.sv
// Shared types and reply-frame constants for the MS53L poll controller.
package ms53l_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        START  = 3'd2,
        SEND   = 3'd3,
        LISTEN = 3'd4,
        DONE   = 3'd5,
        FAIL   = 3'd6
    } state_t;

    localparam logic [7:0] HDR  = 8'h51;
    localparam logic [7:0] TYPE = 8'h0B;
    localparam logic [7:0] FUNC = 8'h05;
    localparam logic [7:0] LEN  = 8'h02;
    localparam int         RSP_LEN = 8;

    typedef logic [2:0] rsp_idx_t;

    // On a mismatch a header byte immediately re-opens a frame.
    function automatic rsp_idx_t resync_idx(input logic [7:0] b);
        return (b == HDR) ? rsp_idx_t'(1) : rsp_idx_t'(0);
    endfunction

endpackage

// File: rtl/ms53l_poll_ctrl_if.sv
// Link-side signals of the poll controller: sender handshake, uart bytes, results.
interface ms53l_poll_ctrl_if;
    logic        cmd_start;
    logic        cmd_tx_en;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic [15:0] data_out;
    logic        data_valid;
    logic        err_timeout;
    logic        busy;

    modport master (
        output cmd_start, data_out, data_valid, err_timeout, busy,
        input  cmd_tx_en, rx_done, rx_data
    );

    modport slave (
        input  cmd_start, data_out, data_valid, err_timeout, busy,
        output cmd_tx_en, rx_done, rx_data
    );
endinterface

// File: rtl/ms53l_rsp_parser.sv
// Reply-frame parser: tracks byte index with header resync, keeps dH in a shadow register.
module ms53l_rsp_parser
    import ms53l_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        frame_ok,
    output logic [15:0] value
);

    rsp_idx_t   idx_reg, idx_next;
    logic [7:0] dh_reg;

    always_comb begin
        idx_next = idx_reg;
        if (clr) begin
            idx_next = '0;
        end else if (rx_done) begin
            case (idx_reg)
                3'd0:    idx_next = (rx_data == HDR)  ? 3'd1 : 3'd0;
                3'd1:    idx_next = (rx_data == TYPE) ? 3'd2 : resync_idx(rx_data);
                3'd4:    idx_next = (rx_data == FUNC) ? 3'd5 : resync_idx(rx_data);
                3'd5:    idx_next = (rx_data == LEN)  ? 3'd6 : resync_idx(rx_data);
                3'd7:    idx_next = '0;
                default: idx_next = idx_reg + 3'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= '0;
            dh_reg  <= '0;
        end else begin
            idx_reg <= idx_next;
            if (!clr && rx_done && idx_reg == 3'd6)
                dh_reg <= rx_data;
        end
    end

    // Completion is combinational so a final byte can beat a same-cycle timeout.
    assign frame_ok = !clr && rx_done && (idx_reg == rsp_idx_t'(RSP_LEN - 1));
    assign value    = {dh_reg, rx_data};

endmodule

// File: rtl/ms53l_poll_ctrl.sv
// Periodic poll scheduler: starts a command frame, counts its bytes, parses the reply, retries on timeout.
module ms53l_poll_ctrl
    import ms53l_pkg::*;
#(
    parameter int POLL_CYCLES    = 5_000_000,
    parameter int TX_BYTES       = 11,
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    ms53l_poll_ctrl_if.master  bus
);

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(TX_BYTES + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t         state_reg, state_next;
    logic [PW-1:0]  period_reg, period_next;
    logic [TW-1:0]  timeout_reg, timeout_next;
    logic [BW-1:0]  byte_reg, byte_next;
    logic [RW-1:0]  retry_reg, retry_next;
    logic [15:0]    data_out_reg;

    logic           frame_ok;
    logic [15:0]    value;
    logic           timeout_hit;
    logic           load_data;

    ms53l_rsp_parser u_parser (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_reg == START),
        .rx_done  (bus.rx_done && state_reg == LISTEN),
        .rx_data  (bus.rx_data),
        .frame_ok (frame_ok),
        .value    (value)
    );

    assign timeout_hit = (timeout_reg == TW'(TIMEOUT_CYCLES - 1));
    assign load_data   = enable && (state_reg == LISTEN) && frame_ok;

    always_comb begin
        state_next   = state_reg;
        period_next  = period_reg;
        timeout_next = timeout_reg;
        byte_next    = byte_reg;
        retry_next   = retry_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next  = WAIT;
                    period_next = '0;
                    retry_next  = '0;
                end
                WAIT: begin
                    if (period_reg == PW'(POLL_CYCLES - 1)) begin
                        state_next   = START;
                        timeout_next = '0;
                    end else begin
                        period_next = period_reg + 1'b1;
                    end
                end
                START, SEND, LISTEN: begin
                    // Free-running across retries; wrapping lines up with the retry START.
                    timeout_next = timeout_hit ? '0 : timeout_reg + 1'b1;
                    if (state_reg == START) begin
                        byte_next  = '0;
                        state_next = SEND;
                    end else if (state_reg == SEND && bus.cmd_tx_en) begin
                        byte_next = byte_reg + 1'b1;
                        if (byte_reg == BW'(TX_BYTES - 1))
                            state_next = LISTEN;
                    end
                    if (state_reg == LISTEN && frame_ok) begin
                        state_next = DONE;
                    end else if (timeout_hit) begin
                        if (retry_reg < RW'(MAX_RETRY)) begin
                            retry_next = retry_reg + 1'b1;
                            state_next = START;
                        end else begin
                            state_next = FAIL;
                        end
                    end
                end
                DONE, FAIL: begin
                    retry_next  = '0;
                    period_next = '0;
                    state_next  = WAIT;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            period_reg   <= '0;
            timeout_reg  <= '0;
            byte_reg     <= '0;
            retry_reg    <= '0;
            data_out_reg <= '0;
        end else begin
            state_reg   <= state_next;
            period_reg  <= period_next;
            timeout_reg <= timeout_next;
            byte_reg    <= byte_next;
            retry_reg   <= retry_next;
            if (load_data)
                data_out_reg <= value;
        end
    end

    assign bus.cmd_start   = (state_reg == START);
    assign bus.data_valid  = (state_reg == DONE);
    assign bus.err_timeout = (state_reg == FAIL);
    assign bus.busy        = (state_reg == START) || (state_reg == SEND) || (state_reg == LISTEN);
    assign bus.data_out    = data_out_reg;

endmodule

// File: tb/tb_ms53l_poll_ctrl.sv
// Directed bench for ms53l_poll_ctrl with a behavioural frame sender and uart byte source.
module tb_ms53l_poll_ctrl;

    localparam int POLL = 100;
    localparam int TMO  = 400;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;

    ms53l_poll_ctrl_if bus_if ();

    ms53l_poll_ctrl #(
        .POLL_CYCLES    (POLL),
        .TX_BYTES       (11),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int dv_seen      = 0;
    int err_seen     = 0;
    logic [7:0] rx_buf [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.data_valid === 1'b1)  dv_seen  <= dv_seen + 1;
        if (bus_if.err_timeout === 1'b1) err_seen <= err_seen + 1;
    end

    task automatic wait_start(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus_if.cmd_start === 1'b1) begin
                n = i;
                break;
            end
        end
        $display("[TB] cmd_start after %0d cycles", n);
    endtask

    task automatic send_tx(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk) bus_if.cmd_tx_en = 1'b1;
            @(negedge clk) bus_if.cmd_tx_en = 1'b0;
        end
        $display("[TB] sender strobed %0d bytes", count);
    endtask

    task automatic send_rx(input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            bus_if.rx_done = 1'b1;
            bus_if.rx_data = rx_buf[i];
            @(negedge clk);
            bus_if.rx_done = 1'b0;
        end
        $display("[TB] uart delivered %0d bytes", len);
    endtask

    task automatic set_frame(input logic [7:0] dh, input logic [7:0] dl);
        rx_buf[0] = 8'h51; rx_buf[1] = 8'h0B; rx_buf[2] = 8'h00; rx_buf[3] = 8'h01;
        rx_buf[4] = 8'h05; rx_buf[5] = 8'h02; rx_buf[6] = dh;    rx_buf[7] = dl;
    endtask

    // Counts cmd_start pulses (including the one just seen) until err_timeout.
    task automatic run_to_fail(output int starts, output int at);
        starts = 1;
        at     = -1;
        for (int i = 1; i <= 4 * TMO + 100; i++) begin
            @(negedge clk);
            if (bus_if.cmd_start === 1'b1) starts++;
            if (bus_if.err_timeout === 1'b1) begin
                at = i;
                break;
            end
        end
        $display("[TB] err_timeout after %0d cycles, %0d starts", at, starts);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus_if.cmd_start !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_start: got %b, expected 0", bus_if.cmd_start); end
        tests_run++; if (bus_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", bus_if.busy); end
        tests_run++; if (bus_if.data_valid !== 1'b0 || bus_if.err_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got dv=%b err=%b, expected 0 0", bus_if.data_valid, bus_if.err_timeout); end
        tests_run++; if (bus_if.data_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_data_out: got %h, expected 0000", bus_if.data_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (bus_if.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_disabled_busy: got %b, expected 0", bus_if.busy); end
        $display("[TB] reset done");
    endtask

    task automatic test_normal_poll;
        int n;
        int base;
        enable = 1'b1;
        wait_start(200, n);
        tests_run++; if (n != POLL + 1) begin tests_failed++; $display("FAIL first_start_cycle: got %0d, expected %0d", n, POLL + 1); end
        tests_run++; if (bus_if.busy !== 1'b1) begin tests_failed++; $display("FAIL busy_in_start: got %b, expected 1", bus_if.busy); end
        send_tx(11);
        set_frame(8'h12, 8'h34);
        base = dv_seen;
        send_rx(8);
        tests_run++; if (bus_if.data_valid !== 1'b1) begin tests_failed++; $display("FAIL normal_dv: got %b, expected 1", bus_if.data_valid); end
        tests_run++; if (bus_if.data_out !== 16'h1234) begin tests_failed++; $display("FAIL normal_data: got %h, expected 1234", bus_if.data_out); end
        @(negedge clk);
        tests_run++; if (bus_if.data_valid !== 1'b0 || dv_seen - base != 1) begin tests_failed++; $display("FAIL normal_dv_width: got dv=%b pulses=%0d, expected 0 and 1", bus_if.data_valid, dv_seen - base); end
    endtask

    task automatic test_resync;
        int n;
        int base;
        wait_start(200, n);
        tests_run++; if (n != POLL) begin tests_failed++; $display("FAIL period_after_done: got %0d, expected %0d", n, POLL); end
        send_tx(11);
        // Junk header leaves the parser at index 3; EE moves it to 4, where the real 51 resyncs.
        rx_buf[0] = 8'hA5; rx_buf[1] = 8'h51; rx_buf[2] = 8'h0B; rx_buf[3] = 8'h7F; rx_buf[4] = 8'hEE;
        rx_buf[5] = 8'h51; rx_buf[6] = 8'h0B; rx_buf[7] = 8'h00; rx_buf[8] = 8'h01;
        rx_buf[9] = 8'h05; rx_buf[10] = 8'h02; rx_buf[11] = 8'h00; rx_buf[12] = 8'h64;
        base = dv_seen;
        send_rx(13);
        tests_run++; if (bus_if.data_out !== 16'h0064) begin tests_failed++; $display("FAIL resync_data: got %h, expected 0064", bus_if.data_out); end
        @(negedge clk);
        tests_run++; if (dv_seen - base != 1) begin tests_failed++; $display("FAIL resync_dv_count: got %0d, expected 1", dv_seen - base); end
    endtask

    task automatic test_timeout;
        int n;
        int starts;
        int at;
        int base;
        wait_start(200, n);
        tests_run++; if (n != POLL) begin tests_failed++; $display("FAIL timeout_first_start: got %0d, expected %0d", n, POLL); end
        base = dv_seen;
        run_to_fail(starts, at);
        tests_run++; if (starts != 4) begin tests_failed++; $display("FAIL timeout_starts: got %0d, expected 4", starts); end
        tests_run++; if (at != 4 * TMO) begin tests_failed++; $display("FAIL timeout_err_cycle: got %0d, expected %0d", at, 4 * TMO); end
        tests_run++; if (bus_if.data_out !== 16'h0064 || dv_seen != base) begin tests_failed++; $display("FAIL timeout_data_kept: got %h dv=%0d, expected 0064 dv=0", bus_if.data_out, dv_seen - base); end
        @(negedge clk);
        tests_run++; if (bus_if.err_timeout !== 1'b0) begin tests_failed++; $display("FAIL err_width: got %b, expected 0", bus_if.err_timeout); end
    endtask

    task automatic test_retry_success;
        int n;
        int starts;
        int at;
        int base_err;
        wait_start(200, n);
        tests_run++; if (n != POLL) begin tests_failed++; $display("FAIL period_after_fail: got %0d, expected %0d", n, POLL); end
        base_err = err_seen;
        wait_start(TMO + 50, n);
        tests_run++; if (n != TMO) begin tests_failed++; $display("FAIL retry_start_cycle: got %0d, expected %0d", n, TMO); end
        send_tx(11);
        set_frame(8'hAB, 8'hCD);
        send_rx(8);
        tests_run++; if (bus_if.data_valid !== 1'b1 || bus_if.data_out !== 16'hABCD) begin tests_failed++; $display("FAIL retry_data: got dv=%b data=%h, expected 1 ABCD", bus_if.data_valid, bus_if.data_out); end
        tests_run++; if (err_seen != base_err) begin tests_failed++; $display("FAIL retry_no_err: got %0d err pulses, expected 0", err_seen - base_err); end
        // A cleared retry count gives the next silent poll all four attempts.
        wait_start(200, n);
        run_to_fail(starts, at);
        tests_run++; if (starts != 4) begin tests_failed++; $display("FAIL retry_cleared: got %0d starts, expected 4", starts); end
    endtask

    task automatic test_abort;
        int n;
        int base;
        wait_start(200, n);
        tests_run++; if (n != POLL + 1) begin tests_failed++; $display("FAIL abort_start: got %0d, expected %0d", n, POLL + 1); end
        send_tx(11);
        set_frame(8'h99, 8'h88);
        base = dv_seen;
        send_rx(4);
        enable = 1'b0;
        @(negedge clk);
        tests_run++; if (bus_if.busy !== 1'b0 || bus_if.cmd_start !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: got busy=%b start=%b, expected 0 0", bus_if.busy, bus_if.cmd_start); end
        repeat (20) @(negedge clk);
        tests_run++; if (dv_seen != base || bus_if.data_out !== 16'hABCD) begin tests_failed++; $display("FAIL abort_no_dv: got dv=%0d data=%h, expected 0 ABCD", dv_seen - base, bus_if.data_out); end
        enable = 1'b1;
        wait_start(200, n);
        tests_run++; if (n != POLL + 1) begin tests_failed++; $display("FAIL reenable_start: got %0d, expected %0d", n, POLL + 1); end
    endtask

    task automatic test_edges;
        int n;
        int s;
        s = cyc;
        send_tx(11);
        set_frame(8'h5A, 8'hA5);
        send_rx(7);
        while (cyc < s + TMO - 1) @(negedge clk);
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = rx_buf[7];
        @(negedge clk);
        bus_if.rx_done = 1'b0;
        tests_run++; if (bus_if.data_valid !== 1'b1 || bus_if.cmd_start !== 1'b0) begin tests_failed++; $display("FAIL byte_vs_timeout: got dv=%b start=%b, expected 1 0", bus_if.data_valid, bus_if.cmd_start); end
        tests_run++; if (bus_if.data_out !== 16'h5AA5) begin tests_failed++; $display("FAIL byte_vs_timeout_data: got %h, expected 5AA5", bus_if.data_out); end
        wait_start(200, n);
        send_tx(5);
        tests_run++; if (bus_if.busy !== 1'b1) begin tests_failed++; $display("FAIL mid_send_busy: got %b, expected 1", bus_if.busy); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus_if.busy !== 1'b0 || bus_if.cmd_start !== 1'b0) begin tests_failed++; $display("FAIL async_reset_ctl: got busy=%b start=%b, expected 0 0", bus_if.busy, bus_if.cmd_start); end
        tests_run++; if (bus_if.data_out !== 16'h0000 || bus_if.data_valid !== 1'b0 || bus_if.err_timeout !== 1'b0) begin tests_failed++; $display("FAIL async_reset_data: got %h dv=%b err=%b, expected 0000 0 0", bus_if.data_out, bus_if.data_valid, bus_if.err_timeout); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] async reset mid-SEND applied");
    endtask

    initial begin
        bus_if.cmd_tx_en = 1'b0;
        bus_if.rx_done   = 1'b0;
        bus_if.rx_data   = 8'h00;
        for (int i = 0; i < 16; i++) rx_buf[i] = 8'h00;
        test_reset();
        test_normal_poll();
        test_resync();
        test_timeout();
        test_retry_success();
        test_abort();
        test_edges();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
